uart_receiver: RTL and testbench

Serial receive front end of the `rsicv` SoC, sitting between the `FPGA_SERIAL_RX` pin and the CPU's memory-mapped UART data/status registers. It oversamples an asynchronous 8N1 line and reassembles each frame into a byte. The byte is held in a single-entry output register with a valid/ready handshake. Framing errors and overruns are reported as one-cycle pulses for the CPU status register.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_receiver.sv | 141 ++++++++++++++
 tb/tb_uart_receiver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing derivation.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } uart_rx_state_t;

   // Core clock cycles per bit on the wire.
   function automatic int unsigned symbol_cycles(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
      return clock_freq / baud_rate;
   endfunction

   // Cycles from start-bit detection to the middle of the start bit.
   function automatic int unsigned half_cycles(input int unsigned clock_freq,
                                               input int unsigned baud_rate);
      return symbol_cycles(clock_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Capture the asynchronous pin, then re-register to let metastability settle.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start/data/stop detection feeding a
// single-entry valid/ready holding register with framing and overrun pulses.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int unsigned SYMBOL = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned HALF   = half_cycles(CLOCK_FREQ, BAUD_RATE);
   localparam int          CNT_W  = (SYMBOL > 1) ? $clog2(SYMBOL) : 1;

   logic           rx;
   uart_rx_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           frame_ok, frame_bad;
   logic [7:0]     dout_q, dout_d;
   logic           vld_q, vld_d;
   logic           fe_q, fe_d;
   logic           ovr_q, ovr_d;
   logic           mid_tick, end_tick, consume;

   sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d_i (serial_in),
      .q_o (rx)
   );

   assign mid_tick = (cnt_q == CNT_W'(HALF));
   assign end_tick = (cnt_q == CNT_W'(SYMBOL - 1));
   assign consume  = vld_q && data_out_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decision; a line held low after a bad stop bit never starts a frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (!rx) state_d = ST_START;
         ST_START:     if (mid_tick) state_d = rx ? ST_IDLE : ST_DATA;
         ST_DATA:      if (end_tick && (bit_cnt_q == 4'd7)) state_d = ST_STOP;
         ST_STOP:      if (end_tick) state_d = rx ? ST_IDLE : ST_WAIT_HIGH;
         ST_WAIT_HIGH: if (rx) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Bit timing, data shifting and end-of-frame qualification.
   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      case (state_q)
         ST_IDLE: cnt_d = '0;
         ST_START: begin
            if (mid_tick) begin
               cnt_d     = '0;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (end_tick) begin
               shift_d   = {rx, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               cnt_d     = '0;
            end
         end
         ST_STOP: begin
            if (end_tick) begin
               cnt_d     = '0;
               frame_ok  = rx;
               frame_bad = !rx;
            end
         end
         ST_WAIT_HIGH: cnt_d = '0;
         default: cnt_d = '0;
      endcase
   end

   // Holding register: accept a new byte if empty or being drained this cycle.
   always_comb begin
      dout_d = dout_q;
      vld_d  = vld_q && !consume;
      fe_d   = frame_bad;
      ovr_d  = 1'b0;
      if (frame_ok) begin
         if (!vld_q || consume) begin
            dout_d = shift_q;
            vld_d  = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // Datapath and output registers; reset abandons any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         dout_q    <= '0;
         vld_q     <= 1'b0;
         fe_q      <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         vld_q     <= vld_d;
         fe_q      <= fe_d;
         ovr_q     <= ovr_d;
      end
   end

   assign data_out       = dout_q;
   assign data_out_valid = vld_q;
   assign framing_error  = fe_q;
   assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at SYMBOL = 16 cycles per bit.
module tb_uart_receiver;

   localparam int SYM = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       serial_in = 1'b1;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready = 1'b1;
   logic       framing_error;
   logic       overrun;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];
   bit  held = 0;
   int  exp_fe = 0, exp_ovr = 0;
   int  fe_cnt = 0, ovr_cnt = 0;
   bit  fe_prev = 0, ovr_prev = 0, prev_hold = 0;
   logic [7:0] prev_data = 8'h00;

   uart_receiver #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(3_125_000)) dut (
      .clk            (clk),
      .rst            (rst),
      .serial_in      (serial_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .framing_error  (framing_error),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one 8N1 frame; the line is left at the stop-bit level.
   task automatic send_bits(input logic [7:0] b, input logic stop);
      serial_in = 1'b0;
      tick(SYM);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         tick(SYM);
      end
      serial_in = stop;
      tick(SYM);
   endtask

   // Reference model of the holding register, then transmit a good frame.
   task automatic send_good(input logic [7:0] b);
      if (data_out_ready) exp_q.push_back(b);
      else if (!held) begin
         exp_q.push_back(b);
         held = 1;
      end else exp_ovr++;
      send_bits(b, 1'b1);
   endtask

   task automatic set_ready(input logic v);
      data_out_ready = v;
      if (v) held = 0;
      tick(2);
   endtask

   // Monitor: pop expected bytes on every handshake, track pulses and stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 0;
         fe_prev   = 0;
         ovr_prev  = 0;
      end else begin
         if (data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) check("unexpected_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
            else check("byte", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
         end
         if (prev_hold && data_out_valid) check("stable", {24'h0, data_out}, {24'h0, prev_data});
         prev_hold = data_out_valid && !data_out_ready;
         prev_data = data_out;
         if (framing_error) begin
            fe_cnt++;
            check("fe_width", {31'h0, fe_prev}, 32'h0);
         end
         if (overrun) begin
            ovr_cnt++;
            check("ovr_width", {31'h0, ovr_prev}, 32'h0);
         end
         fe_prev  = framing_error;
         ovr_prev = overrun;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n, fe0, ovr0, gap;
      logic any;
      logic [7:0] b;

      tick(3);
      check("rst_data", {24'h0, data_out}, 32'h0);
      check("rst_valid", {31'h0, data_out_valid}, 32'h0);
      check("rst_pulses", {30'h0, framing_error, overrun}, 32'h0);
      rst = 1'b0;
      any = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         any = any | data_out_valid | framing_error | overrun | (|data_out);
      end
      check("idle_quiet", {31'h0, any}, 32'h0);

      // 0xA5 held with ready low, latency measured from the start edge
      data_out_ready = 1'b0;
      n = 0;
      fork
         send_good(8'hA5);
         begin
            while (!data_out_valid && n < 300) begin
               @(posedge clk);
               #1;
               n++;
            end
         end
      join
      check("latency_in_window", {31'h0, (n >= 154 && n <= 156)}, 32'h1);
      check("a5_valid", {31'h0, data_out_valid}, 32'h1);
      check("a5_data", {24'h0, data_out}, 32'hA5);
      tick(30);
      data_out_ready = 1'b1;
      tick(1);
      check("valid_drop", {31'h0, data_out_valid}, 32'h0);
      data_out_ready = 1'b0;
      held = 0;
      tick(5);

      // Back-to-back with ready low: second byte overruns
      ovr0 = ovr_cnt;
      send_good(8'h3C);
      send_good(8'hC3);
      tick(4);
      check("ovr_once", ovr_cnt - ovr0, 1);
      check("ovr_data_kept", {24'h0, data_out}, 32'h3C);
      check("ovr_valid", {31'h0, data_out_valid}, 32'h1);
      set_ready(1'b1);
      ovr0 = ovr_cnt;
      send_good(8'h3C);
      send_good(8'hC3);
      tick(4);
      check("no_ovr_ready", ovr_cnt - ovr0, 0);

      // Bad stop bit, break, then a good frame
      fe0 = fe_cnt;
      exp_fe++;
      send_bits(8'h55, 1'b0);
      tick(100);
      serial_in = 1'b1;
      tick(20);
      check("fe_once", fe_cnt - fe0, 1);
      send_good(8'h0F);
      tick(4);

      // Short glitch on an idle line
      fe0 = fe_cnt;
      ovr0 = ovr_cnt;
      serial_in = 1'b0;
      tick(4);
      serial_in = 1'b1;
      tick(200);
      check("glitch_quiet", {31'h0, data_out_valid}, 32'h0);
      check("glitch_pulses", (fe_cnt - fe0) + (ovr_cnt - ovr0), 0);

      // Reset in the middle of a frame
      serial_in = 1'b0;
      tick(SYM);
      serial_in = 1'b1;
      tick(SYM);
      serial_in = 1'b0;
      tick(SYM / 2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      serial_in = 1'b1;
      check("rst_mid_data", {24'h0, data_out}, 32'h0);
      tick(200);
      check("rst_mid_quiet", {31'h0, data_out_valid}, 32'h0);
      check("rst_mid_pulses", (fe_cnt - fe0) + (ovr_cnt - ovr0), 0);
      send_good(8'h81);
      tick(4);

      // Randomized frames, gaps and consumer readiness
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 3) == 0) set_ready(!data_out_ready);
         b = 8'($urandom);
         send_good(b);
         gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 30));
         tick(gap);
      end
      set_ready(1'b1);
      tick(10);

      check("queue_drained", exp_q.size(), 0);
      check("fe_total", fe_cnt, exp_fe);
      check("ovr_total", ovr_cnt, exp_ovr);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
